// File: rtl/vr_conditioner.sv
// Crank/cam VR input conditioner: synchronizes and glitch-filters both sensor inputs,
// blanks noise edges on the crank channel and measures the crank tooth period.
module vr_conditioner #(
    parameter int FILT_W      = 4,
    parameter int PER_W       = 24,
    parameter int BLANK_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vr_in,
    input  logic              cam_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              blank_en,
    output logic              cap_out,
    output logic              cap_edge,
    output logic              cam_out,
    output logic [PER_W-1:0]  tooth_period,
    output logic              period_valid,
    output logic              ovf,
    output logic [7:0]        noise_cnt
);

    typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_REJECT} state_t;

    localparam logic [PER_W-1:0] PER_MAX    = '1;
    localparam logic [PER_W-1:0] PER_PRESAT = PER_MAX - PER_W'(1);

    logic              vr_s1, vr_s2, cam_s1, cam_s2;
    logic [FILT_W-1:0] crank_cnt, cam_cnt;
    logic              crank_lvl, cam_lvl;
    logic              crank_tog, cam_tog;
    logic              crank_rise, crank_fall;
    state_t            state_q, state_d;
    logic              accept, reject, in_blank, first_edge, have_prior;
    logic [PER_W-1:0]  period_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vr_s1  <= 1'b0;
            vr_s2  <= 1'b0;
            cam_s1 <= 1'b0;
            cam_s2 <= 1'b0;
        end else begin
            vr_s1  <= vr_in;
            vr_s2  <= vr_s1;
            cam_s1 <= cam_in;
            cam_s2 <= cam_s1;
        end
    end

    // ">=" rather than "==" so a filt_len lowered below the running count toggles at the next compare
    assign crank_tog = (vr_s2 != crank_lvl) && (crank_cnt >= filt_len);
    assign cam_tog   = (cam_s2 != cam_lvl) && (cam_cnt >= filt_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crank_cnt <= '0;
            crank_lvl <= 1'b0;
        end else if (vr_s2 == crank_lvl) begin
            crank_cnt <= '0;
        end else if (crank_tog) begin
            crank_lvl <= ~crank_lvl;
            crank_cnt <= '0;
        end else begin
            crank_cnt <= crank_cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cam_cnt <= '0;
            cam_lvl <= 1'b0;
        end else if (cam_s2 == cam_lvl) begin
            cam_cnt <= '0;
        end else if (cam_tog) begin
            cam_lvl <= ~cam_lvl;
            cam_cnt <= '0;
        end else begin
            cam_cnt <= cam_cnt + FILT_W'(1);
        end
    end

    assign cam_out = cam_lvl;

    // Edge events are taken from the filter's toggle so cap_out moves in the same cycle as the filtered level
    assign crank_rise = crank_tog & ~crank_lvl;
    assign crank_fall = crank_tog & crank_lvl;
    assign in_blank   = blank_en && period_valid && (period_cnt < (tooth_period >> BLANK_SHIFT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (crank_rise) begin
                    if (in_blank) begin
                        reject  = 1'b1;
                        state_d = ST_REJECT;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH, ST_REJECT: begin
                if (crank_fall) begin
                    state_d = ST_LOW;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    assign cap_out = (state_q == ST_HIGH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_edge  <= 1'b0;
            noise_cnt <= '0;
        end else begin
            cap_edge <= accept;
            if (reject && (noise_cnt != 8'hFF)) begin
                noise_cnt <= noise_cnt + 8'd1;
            end
        end
    end

    // An edge landing on the saturation cycle counts as the first edge of a fresh measurement
    assign first_edge = !have_prior || ovf || (period_cnt == PER_PRESAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt   <= '0;
            tooth_period <= '0;
            period_valid <= 1'b0;
            ovf          <= 1'b0;
            have_prior   <= 1'b0;
        end else if (accept) begin
            period_cnt <= PER_W'(1);
            ovf        <= 1'b0;
            have_prior <= 1'b1;
            if (first_edge) begin
                period_valid <= 1'b0;
            end else begin
                tooth_period <= period_cnt;
                period_valid <= 1'b1;
            end
        end else if (period_cnt != PER_MAX) begin
            period_cnt <= period_cnt + PER_W'(1);
            if (period_cnt == PER_PRESAT) begin
                ovf          <= 1'b1;
                period_valid <= 1'b0;
                have_prior   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vr_conditioner.md
VR_CONDITIONER -- requirements
Module: vr_conditioner

Interface
REQ-001 Parameter FILT_W, default 4, width of glitch-filter length and counter.
REQ-002 Parameter PER_W, default 24, width of tooth-period counter.
REQ-003 Parameter BLANK_SHIFT, default 2, blanking window = tooth_period >> BLANK_SHIFT.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 vr_in  input  1  raw crank VR comparator output, asynchronous to clk.
REQ-007 cam_in  input  1  raw cam sensor output, asynchronous to clk.
REQ-008 filt_len  input  FILT_W  glitch-filter length, quasi-static.
REQ-009 blank_en  input  1  enables period-based noise blanking.
REQ-010 cap_out  output  1  conditioned crank level, feeds the angle generator's cap input.
REQ-011 cap_edge  output  1  one-cycle pulse on each accepted crank rising edge.
REQ-012 cam_out  output  1  conditioned cam level, feeds the angle generator's cam input.
REQ-013 tooth_period  output  PER_W  clk cycles between the last two accepted edges.
REQ-014 period_valid  output  1  tooth_period holds a valid measurement.
REQ-015 ovf  output  1  period counter saturated since the last accepted edge.
REQ-016 noise_cnt  output  8  count of rejected crank edges, saturating.

Function
REQ-017 vr_in and cam_in SHALL each pass through a 2-flop synchronizer.
REQ-018 Each channel SHALL have a filter counter: incremented while sync input != filtered level, cleared when equal.
REQ-019 Filter: when sync differs and counter == filt_len, filtered level SHALL toggle and counter clear in that cycle; filt_len=0 gives 1-cycle filter delay.
REQ-020 Input-to-filtered latency SHALL be 2 + filt_len + 1 cycles for a clean step.
REQ-021 A pulse shorter than filt_len+1 synchronized cycles SHALL not change the filtered level.
REQ-022 cam_out SHALL equal the filtered cam level; no blanking on cam.
REQ-023 Crank FSM states: LOW, HIGH, REJECT; reset state LOW.
REQ-024 LOW: filtered crank rises and edge accepted -> HIGH, cap_edge=1 that cycle.
REQ-025 Edge rejected iff blank_en=1 and period_valid=1 and period_cnt < (tooth_period >> BLANK_SHIFT); otherwise accepted.
REQ-026 LOW: filtered crank rises and edge rejected -> REJECT, noise_cnt += 1 saturating at 255.
REQ-027 HIGH or REJECT: filtered crank falls -> LOW.
REQ-028 cap_out SHALL be 1 only in HIGH; registered, no combinational path from inputs.
REQ-029 period_cnt SHALL increment every cycle, saturating at all-ones; on reaching all-ones ovf=1 and period_valid=0.
REQ-030 On accepted edge with ovf=0 and a prior accepted edge since reset/overflow: tooth_period <= period_cnt, period_valid <= 1.
REQ-031 On first accepted edge after reset or after overflow: tooth_period unchanged, period_valid stays 0, ovf cleared.
REQ-032 Every accepted edge SHALL load period_cnt with 1; rejected edges SHALL not affect period_cnt.
REQ-033 Accepted edge coinciding with saturation cycle: edge handling wins (period_cnt <= 1, ovf=0, treated as REQ-031).
REQ-034 filt_len change mid-count: new value SHALL apply from the next comparison; no spurious toggle beyond REQ-019.

Reset
REQ-035 rst low SHALL asynchronously clear synchronizers, filter counters, filtered levels, FSM (LOW), period_cnt, tooth_period, period_valid, ovf, noise_cnt, cap_out, cap_edge, cam_out to 0.
REQ-036 Reset asserted mid-tooth SHALL discard the measurement; the first post-reset edge follows REQ-031.

Verification
REQ-037 filt_len=3, vr_in high 3 cycles then low -> cap_out stays 0, noise_cnt 0; high 10 cycles -> cap_out rises 6 cycles after vr_in, cap_edge one cycle.
REQ-038 filt_len=0, blank_en=0, rising edges every 400 cycles -> second edge gives period_valid=1, tooth_period=400; stays 400 thereafter.
REQ-039 blank_en=1, tooth_period=400, glitch edge 50 cycles after accepted edge -> rejected, noise_cnt=1, cap_out 0, next edge at 400 gives tooth_period=400.
REQ-040 60-2 pattern, tooth 400 cycles, gap 1200 -> all 58 edges accepted, tooth_period 1200 after gap, 400 on next tooth, noise_cnt 0.
REQ-041 PER_W=8, no edges 300 cycles -> ovf=1, period_valid=0; next edge clears ovf, period_valid stays 0; following edge sets it.
REQ-042 rst pulsed low mid-tooth with cap_out=1 -> all outputs 0 immediately, first subsequent edge gives period_valid=0.
